// File: rtl/spi_reg_ctrl.sv
// Command/register controller behind spi_slave: decodes a command byte, then
// burst-reads or burst-writes a small register file, and feeds the next
// transmit byte back to spi_slave.
module spi_reg_ctrl #(
  parameter int unsigned ADDR_W  = 4,
  parameter logic [7:0]  ID_BYTE = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cs,
  input  logic [7:0]                  dr,
  input  logic                        ack,
  output logic [7:0]                  ds,
  output logic [(2**ADDR_W)*8-1:0]    reg_q,
  output logic                        wr_stb,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic [7:0]                  wr_data,
  output logic                        busy
);

  localparam int unsigned NREGS = 2**ADDR_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WDATA = 3'd2,
    RDATA = 3'd3,
    DRAIN = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          cs_sync_q, cs_sync_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ai_q, ai_d;
  logic                err_q, err_d;
  logic [3:0]          frame_cnt_q, frame_cnt_d;
  logic                seen_q, seen_d;
  logic [7:0]          ds_q, ds_d;
  logic [7:0]          regs_q [NREGS];
  logic [7:0]          regs_d [NREGS];
  logic                wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                busy_q, busy_d;

  logic                cs_fall, cs_rise, cmd_rsvd;
  logic [ADDR_W-1:0]   cmd_addr;

  // Edge detection on the synchronised chip select (stage2 is the oldest).
  // The synchroniser resets low so a cs held low across reset cannot start a frame.
  always_comb begin
    cs_sync_d = {cs_sync_q[1:0], cs};
    cs_fall   = cs_sync_q[2] & ~cs_sync_q[1];
    cs_rise   = ~cs_sync_q[2] & cs_sync_q[1];
    cmd_rsvd  = ((dr[5:0] >> ADDR_W) != 6'd0);
    cmd_addr  = dr[ADDR_W-1:0];
  end

  // Frame sequencing, register writes and transmit-byte scheduling.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    ai_d        = ai_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    seen_d      = seen_q;
    ds_d        = ds_q;
    regs_d      = regs_q;
    wr_stb_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    case (state_q)
      IDLE: begin
        seen_d = 1'b0;
        ds_d   = {err_q, 3'b000, frame_cnt_q};
        if (cs_fall) state_d = CMD;
      end
      CMD: begin
        ds_d = {err_q, 3'b000, frame_cnt_q};
        if (ack) begin
          seen_d = 1'b1;
          addr_d = cmd_addr;
          ai_d   = dr[6];
          // Status was just shifted out, so the error flag clears here.
          err_d  = 1'b0;
          if (cmd_rsvd) begin
            err_d   = 1'b1;
            state_d = DRAIN;
            ds_d    = 8'hFF;
          end else if (dr[7]) begin
            state_d = RDATA;
            ds_d    = regs_q[cmd_addr];
          end else begin
            state_d = WDATA;
            ds_d    = {1'b0, 3'b000, frame_cnt_q};
          end
        end
      end
      WDATA: begin
        if (ack) begin
          seen_d = 1'b1;
          ds_d   = dr;
          if (addr_q != '0) begin
            regs_d[addr_q] = dr;
            wr_stb_d       = 1'b1;
            wr_addr_d      = addr_q;
            wr_data_d      = dr;
          end else begin
            err_d = 1'b1;
          end
          if (ai_q) addr_d = addr_q + ADDR_W'(1);
        end
      end
      RDATA: begin
        if (ack) begin
          seen_d = 1'b1;
          if (ai_q) addr_d = addr_q + ADDR_W'(1);
          ds_d = regs_q[addr_d];
        end
      end
      DRAIN: begin
        ds_d = 8'hFF;
        if (ack) seen_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A byte landing with the cs rising edge is processed above, then the frame closes.
    if (state_q != IDLE && cs_rise) begin
      state_d = IDLE;
      if (seen_d) frame_cnt_d = frame_cnt_q + 4'd1;
      ds_d = {err_d, 3'b000, frame_cnt_d};
    end

    regs_d[0] = ID_BYTE;
    busy_d    = (state_d != IDLE);
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cs_sync_q   <= 3'b000;
      addr_q      <= '0;
      ai_q        <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= 4'd0;
      seen_q      <= 1'b0;
      ds_q        <= 8'h00;
      wr_stb_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'h00;
      busy_q      <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == 0) ? ID_BYTE : 8'h00;
      end
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      addr_q      <= addr_d;
      ai_q        <= ai_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      seen_q      <= seen_d;
      ds_q        <= ds_d;
      wr_stb_q    <= wr_stb_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Flatten the register file onto the output bus.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NREGS; i++) begin
      reg_q[8*i +: 8] = regs_q[i];
    end
  end

  assign ds      = ds_q;
  assign wr_stb  = wr_stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: drives cs and spi_slave-style ack/dr strobes.
module tb_spi_reg_ctrl;

  logic         clk;
  logic         rst;
  logic         cs;
  logic [7:0]   dr;
  logic         ack;
  logic [7:0]   ds;
  logic [127:0] reg_q;
  logic         wr_stb;
  logic [3:0]   wr_addr;
  logic [7:0]   wr_data;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  spi_reg_ctrl #(.ADDR_W(4), .ID_BYTE(8'hA5)) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .dr      (dr),
    .ack     (ack),
    .ds      (ds),
    .reg_q   (reg_q),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One received byte: a single-cycle ack, with junk on dr otherwise.
  task automatic send_byte(input logic [7:0] b);
    repeat (3) tick();
    dr  = b;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    dr  = 8'h5C;
  endtask

  task automatic frame_start();
    cs = 1'b0;
    repeat (6) tick();
    check("busy_start", {127'd0, busy}, 128'd1);
  endtask

  task automatic frame_end();
    cs = 1'b1;
    repeat (6) tick();
    check("busy_end", {127'd0, busy}, 128'd0);
  endtask

  task automatic check_wr(input string tag, input logic [3:0] a, input logic [7:0] d);
    check({tag, "_stb"},  {127'd0, wr_stb}, 128'd1);
    check({tag, "_addr"}, {124'd0, wr_addr}, {124'd0, a});
    check({tag, "_data"}, {120'd0, wr_data}, {120'd0, d});
  endtask

  task automatic check_ds(input string tag, input logic [7:0] d);
    check(tag, {120'd0, ds}, {120'd0, d});
  endtask

  initial begin
    rst = 1'b1;
    cs  = 1'b1;
    ack = 1'b0;
    dr  = 8'h5C;
    repeat (3) tick();
    check_ds("rst_ds", 8'h00);
    check("rst_regq", reg_q, 128'hA5);
    check("rst_wrstb", {127'd0, wr_stb}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    rst = 1'b0;
    repeat (6) tick();
    check("post_rst_busy", {127'd0, busy}, 128'd0);

    // Frame 1: write burst to regs 1..3
    frame_start();
    check_ds("f1_status", 8'h00);
    send_byte(8'h41);
    check("f1_cmd_nostb", {127'd0, wr_stb}, 128'd0);
    send_byte(8'h11);
    check_wr("f1_w1", 4'd1, 8'h11);
    check_ds("f1_echo1", 8'h11);
    tick();
    check("f1_stb_pulse", {127'd0, wr_stb}, 128'd0);
    send_byte(8'h22);
    check_wr("f1_w2", 4'd2, 8'h22);
    send_byte(8'h33);
    check_wr("f1_w3", 4'd3, 8'h33);
    frame_end();
    check_ds("f1_end_status", 8'h01);
    check("f1_regq", reg_q, 128'h332211A5);

    // Frame 2: read burst from reg 1
    frame_start();
    check_ds("f2_status", 8'h01);
    send_byte(8'hC1);
    check_ds("f2_rd1", 8'h11);
    check("f2_nostb", {127'd0, wr_stb}, 128'd0);
    send_byte(8'hE7);
    check_ds("f2_rd2", 8'h22);
    send_byte(8'h18);
    check_ds("f2_rd3", 8'h33);
    check("f2_nostb3", {127'd0, wr_stb}, 128'd0);
    send_byte(8'h00);
    check_ds("f2_rd4", 8'h00);
    frame_end();
    check_ds("f2_end_status", 8'h02);
    check("f2_regq", reg_q, 128'h332211A5);

    // Frame 3: write reg 15 then wrap to reg 0 (dropped, sets err)
    frame_start();
    send_byte(8'h4F);
    send_byte(8'hAA);
    check_wr("f3_w15", 4'd15, 8'hAA);
    send_byte(8'hBB);
    check("f3_wrap_nostb", {127'd0, wr_stb}, 128'd0);
    check_ds("f3_echo", 8'hBB);
    frame_end();
    check_ds("f3_end_status", 8'h83);
    check("f3_regq", reg_q, 128'hAA000000_00000000_00000000_332211A5);

    // Frame 4: status shows err, command clears it; read reg 15 without AI
    frame_start();
    check_ds("f4_status", 8'h83);
    send_byte(8'h8F);
    check_ds("f4_rd1", 8'hAA);
    send_byte(8'h00);
    check_ds("f4_rd2", 8'hAA);
    frame_end();
    check_ds("f4_end_status", 8'h04);

    // Frame 5: reserved bits set -> drain
    frame_start();
    send_byte(8'h30);
    check_ds("f5_drain", 8'hFF);
    send_byte(8'h77);
    check("f5_nostb", {127'd0, wr_stb}, 128'd0);
    check_ds("f5_drain2", 8'hFF);
    frame_end();
    check_ds("f5_end_status", 8'h85);
    check("f5_regq", reg_q, 128'hAA000000_00000000_00000000_332211A5);

    // Frame 6: read reg 0 (ID byte) twice
    frame_start();
    check_ds("f6_status", 8'h85);
    send_byte(8'h80);
    check_ds("f6_id1", 8'hA5);
    send_byte(8'h01);
    check_ds("f6_id2", 8'hA5);
    frame_end();
    check_ds("f6_end_status", 8'h06);

    // Frame 7: abort after write command, no data
    frame_start();
    send_byte(8'h42);
    check("f7_nostb", {127'd0, wr_stb}, 128'd0);
    frame_end();
    check_ds("f7_end_status", 8'h07);
    check("f7_regq", reg_q, 128'hAA000000_00000000_00000000_332211A5);

    // Frame 8: data ack coincides with detected cs rising edge
    frame_start();
    send_byte(8'h46);
    repeat (3) tick();
    cs = 1'b1;
    tick();
    tick();
    dr  = 8'h66;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    dr  = 8'h5C;
    check_wr("f8_w6", 4'd6, 8'h66);
    check("f8_idle", {127'd0, busy}, 128'd0);
    check_ds("f8_status", 8'h08);
    tick();
    check("f8_stb_once", {127'd0, wr_stb}, 128'd0);
    check("f8_regq", reg_q, 128'hAA000000_00000000_00660000_332211A5);

    // Frame 9: reset in the middle of a write burst
    repeat (4) tick();
    frame_start();
    send_byte(8'h41);
    send_byte(8'h99);
    check_wr("f9_w1", 4'd1, 8'h99);
    rst = 1'b1;
    #1;
    check("f9_rst_busy", {127'd0, busy}, 128'd0);
    check("f9_rst_regq", reg_q, 128'hA5);
    check("f9_rst_stb", {127'd0, wr_stb}, 128'd0);
    check_ds("f9_rst_ds", 8'h00);
    tick();
    rst = 1'b0;
    send_byte(8'h12);
    check("f9_ign_stb", {127'd0, wr_stb}, 128'd0);
    repeat (6) tick();
    send_byte(8'h13);
    check("f9_ign_stb2", {127'd0, wr_stb}, 128'd0);
    check("f9_ign_busy", {127'd0, busy}, 128'd0);
    check("f9_ign_regq", reg_q, 128'hA5);
    cs = 1'b1;
    repeat (6) tick();
    check_ds("f9_idle_ds", 8'h00);

    // Frame 10: controller works again after reset
    frame_start();
    send_byte(8'h43);
    send_byte(8'h5A);
    check_wr("f10_w3", 4'd3, 8'h5A);
    frame_end();
    check_ds("f10_end_status", 8'h01);
    check("f10_regq", reg_q, 128'h5A0000A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
